addsub_multicycle: RTL and testbench

- Parametrised, multi-cycle signed adder/subtractor for the ALU.
- Replaces the single-cycle 64-bit ripple adder for long operands.
- Computes the result CHUNK bits per cycle, least-significant slice first, with the carry held in a register between slices.
- Returns a result plus Y-86 style condition flags (ZF, SF, OF) and a carry flag, using a valid/ready handshake on both input and output.

---
 rtl/addsub_multicycle.sv | 105 ++++++++++
 tb/tb_addsub_multicycle.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_multicycle.sv
// addsub_multicycle: signed add/subtract computed CHUNK bits per cycle, LSB slice first,
// with Y86-style ZF/SF/OF plus raw carry and valid/ready handshakes on both sides.
module addsub_multicycle #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d, cf_q, cf_d;
  logic [CHUNK:0]   sum;
  logic             last;

  // b is stored pre-inverted for subtraction so CALC is a plain add with carry-in
  always_comb begin
    sum = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, b_q[idx_q*CHUNK +: CHUNK]} + (CHUNK+1)'(carry_q);
    last = idx_q == IW'(NCHUNK - 1);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    result_d = result_q;
    idx_d = idx_q;
    carry_d = carry_q;
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    cf_d = cf_q;
    if (state_q == IDLE && in_valid) begin
      a_d = a;
      b_d = sub ? ~b : b;
      carry_d = sub;
      result_d = '0;
      idx_d = '0;
      state_d = CALC;
    end else if (state_q == CALC) begin
      result_d[idx_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      carry_d = sum[CHUNK];
      idx_d = last ? '0 : idx_q + IW'(1);
      if (last) begin
        state_d = DONE;
        zf_d = result_d == '0;
        sf_d = result_d[WIDTH-1];
        of_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
        cf_d = sum[CHUNK];
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
      cf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      result_q <= result_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
      cf_q <= cf_d;
    end
  end

  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign zf = zf_q;
  assign sf = sf_q;
  assign of = of_q;
  assign cf = cf_q;
endmodule

// File: tb/tb_addsub_multicycle.sv
// tb_addsub_multicycle: directed and random scoreboard checks of addsub_multicycle
// across several WIDTH/CHUNK configurations against an arithmetic reference model.
module tb_addsub_multicycle;
  typedef struct {
    logic [63:0] r;
    logic zf, sf, of, cf;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic dir_done = 1'b0;
  logic rst_s;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mask(int w);
    return w == 64 ? '1 : (64'd1 << w) - 64'd1;
  endfunction

  // Reference: exact signed arithmetic in a wide integer, overflow by range test,
  // carry as unsigned overflow (add) or absence of borrow (sub).
  function automatic exp_t model(int w, logic [63:0] a_in, logic [63:0] b_in, logic s);
    exp_t e;
    logic [63:0] a, b;
    logic [64:0] t;
    logic signed [66:0] sa, sb, ex, lim;
    a = a_in & mask(w);
    b = b_in & mask(w);
    t = s ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    e.r = t[63:0] & mask(w);
    e.cf = s ? (a >= b) : t[w];
    sa = $signed({3'b0, a});
    sb = $signed({3'b0, b});
    if (a[w-1]) sa -= (67'sd1 <<< w);
    if (b[w-1]) sb -= (67'sd1 <<< w);
    ex = s ? sa - sb : sa + sb;
    lim = 67'sd1 <<< (w - 1);
    e.of = (ex >= lim) || (ex < -lim);
    e.zf = e.r == 64'd0;
    e.sf = e.r[w-1];
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(logic [63:0] r, logic z, logic sg, logic o, logic c);
    exp_t e;
    e.r = r;
    e.zf = z;
    e.sf = sg;
    e.of = o;
    e.cf = c;
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [63:0] rnd(int w);
    case ($urandom_range(0, 7))
      0: return '1;
      1: return 64'd1 << (w - 1);
      2: return (64'd1 << (w - 1)) - 64'd1;
      3: return 64'd0;
      4: return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Directed instance, default parameters
  logic rst0, iv0, ir0, sub0, ov0, or0, zf0, sf0, of0, cf0;
  logic [63:0] a0, b0, r0;
  exp_t q0[$];
  logic seen0 = 1'b0;

  addsub_multicycle #(.WIDTH(64), .CHUNK(16)) u0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .sub(sub0), .a(a0), .b(b0),
    .out_valid(ov0), .out_ready(or0), .result(r0), .zf(zf0), .sf(sf0), .of(of0), .cf(cf0)
  );

  always @(negedge clk) begin
    exp_t e;
    if (rst0) seen0 = 1'b0;
    else begin
      if (ov0 && !seen0) begin
        seen0 = 1'b1;
        chk("u0_pending", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) chk("u0_latency", 64'(cyc - q0[0].acc), 64'd4);
      end
      if (ov0 && or0 && q0.size() != 0) begin
        e = q0.pop_front();
        chk("u0_result", r0, e.r);
        chk("u0_flags", 64'({zf0, sf0, of0, cf0}), 64'({e.zf, e.sf, e.of, e.cf}));
        seen0 = 1'b0;
      end
    end
  end

  task automatic issue0(logic [63:0] a, logic [63:0] b, logic s, exp_t e);
    int k = 0;
    @(posedge clk);
    #1;
    a0 = a;
    b0 = b;
    sub0 = s;
    iv0 = 1'b1;
    @(negedge clk);
    while (!ir0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("u0_accept", 64'(ir0), 64'd1);
    e.acc = cyc + 1;
    q0.push_back(e);
    @(posedge clk);
    #1 iv0 = 1'b0;
  endtask

  task automatic wait_done0();
    int k = 0;
    while (q0.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("u0_drain", 64'(q0.size()), 64'd0);
    @(posedge clk);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic rs;
    int k;
    rst0 = 1'b1;
    iv0 = 1'b0;
    or0 = 1'b1;
    sub0 = 1'b0;
    a0 = '0;
    b0 = '0;
    @(negedge clk);
    chk("rst_in_ready", 64'(ir0), 64'd1);
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_result", r0, 64'd0);
    chk("rst_flags", 64'({zf0, sf0, of0, cf0}), 64'd0);
    @(negedge clk);
    rst0 = 1'b0;
    issue0(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk(64'h8000_0000_0000_0000, 0, 1, 1, 0));
    issue0(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, mk(64'h0000_0000_0001_0000, 0, 0, 0, 0));
    issue0(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk(64'd0, 1, 0, 0, 1));
    issue0(64'd5, 64'd5, 1'b1, mk(64'd0, 1, 0, 0, 1));
    issue0(64'h8000_0000_0000_0000, 64'd1, 1'b1, mk(64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1));
    issue0(64'd3, 64'd7, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0, 0));
    wait_done0();
    // Backpressure: hold the result while inputs churn
    #1 or0 = 1'b0;
    issue0(64'h1234, 64'h4321, 1'b0, mk(64'h5555, 0, 0, 0, 0));
    k = 0;
    while (!ov0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      a0 = {$urandom, $urandom};
      b0 = {$urandom, $urandom};
      sub0 = 1'($urandom);
      iv0 = 1'($urandom);
      @(negedge clk);
      chk("bp_result", r0, 64'h5555);
      chk("bp_flags", 64'({zf0, sf0, of0, cf0}), 64'd0);
      chk("bp_in_ready", 64'(ir0), 64'd0);
      chk("bp_out_valid", 64'(ov0), 64'd1);
    end
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    or0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 64'(ov0), 64'd0);
    chk("bp_release_in_ready", 64'(ir0), 64'd1);
    // Asynchronous reset two cycles into CALC
    issue0(64'd9, 64'd9, 1'b0, mk(64'd18, 0, 0, 0, 0));
    @(posedge clk);
    #1 chk("calc_busy", 64'(ir0), 64'd0);
    @(posedge clk);
    #3 rst0 = 1'b1;
    #1;
    chk("arst_out_valid", 64'(ov0), 64'd0);
    chk("arst_in_ready", 64'(ir0), 64'd1);
    chk("arst_result", r0, 64'd0);
    chk("arst_flags", 64'({zf0, sf0, of0, cf0}), 64'd0);
    q0.delete();
    @(negedge clk);
    rst0 = 1'b0;
    issue0(64'd2, 64'd3, 1'b0, mk(64'd5, 0, 0, 0, 0));
    wait_done0();
    for (int i = 0; i < 200; i++) begin
      ra = rnd(64);
      rb = rnd(64);
      rs = 1'($urandom);
      issue0(ra, rb, rs, model(64, ra, rb, rs));
    end
    wait_done0();
    dir_done = 1'b1;
  end

  // Parameter sweep with fully random handshakes
  initial begin
    rst_s = 1'b1;
    repeat (3) @(negedge clk);
    rst_s = 1'b0;
  end

  for (genvar g = 1; g < 5; g++) begin : cfg
    localparam int W = g == 4 ? 8 : 64;
    localparam int C = g == 1 ? 1 : g == 2 ? 8 : g == 3 ? 64 : 4;
    localparam int N = W / C;
    localparam int OPS = N >= 32 ? 400 : 1000;
    logic iv, ir, s, ov, ordy, zf, sf, of, cf;
    logic [W-1:0] a, b, r;
    exp_t q[$];
    logic seen = 1'b0;
    logic done = 1'b0;
    int ndone = 0;
    string nm;

    addsub_multicycle #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst_s), .in_valid(iv), .in_ready(ir), .sub(s), .a(a), .b(b),
      .out_valid(ov), .out_ready(ordy), .result(r), .zf(zf), .sf(sf), .of(of), .cf(cf)
    );

    initial begin
      int k = 0;
      nm = $sformatf("W%0dC%0d", W, C);
      iv = 1'b0;
      ordy = 1'b1;
      s = 1'b0;
      a = '0;
      b = '0;
      wait (!rst_s);
      while (ndone < OPS) begin
        @(posedge clk);
        #1;
        iv = $urandom_range(0, 3) != 0;
        ordy = $urandom_range(0, 3) != 0;
        s = 1'($urandom);
        a = W'(rnd(W));
        b = W'(rnd(W));
      end
      @(posedge clk);
      #1;
      iv = 1'b0;
      ordy = 1'b1;
      while (q.size() != 0 && k < 300) begin
        @(negedge clk);
        k++;
      end
      chk({nm, "_drain"}, 64'(q.size()), 64'd0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      exp_t e;
      if (!rst_s) begin
        if (iv && ir) begin
          e = model(W, 64'(a), 64'(b), s);
          e.acc = cyc + 1;
          q.push_back(e);
        end
        if (ov && !seen) begin
          seen = 1'b1;
          chk({nm, "_pending"}, 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) chk({nm, "_latency"}, 64'(cyc - q[0].acc), 64'(N));
        end
        if (ov && ordy && q.size() != 0) begin
          e = q.pop_front();
          chk({nm, "_result"}, 64'(r), e.r);
          chk({nm, "_flags"}, 64'({zf, sf, of, cf}), 64'({e.zf, e.sf, e.of, e.cf}));
          seen = 1'b0;
          ndone++;
        end
      end
    end
  end

  initial begin
    wait (dir_done && cfg[1].done && cfg[2].done && cfg[3].done && cfg[4].done);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
